// File: rtl/jk_bank_arbiter.sv
// rtl/jk_bank_arbiter.sv - round-robin command arbiter and sequencer for a bank of JK flip-flops
//
// Purpose: picks one of NREQ requesters at a time (round robin from ptr), drives the
// selected bit's j/k pair for exactly one clock, and optionally reads the bit back.
// Build option: define JK_BANK_ARBITER_VERIFY_EN to add the CHECK state and a live err;
// without it DRIVE returns straight to IDLE, err is 0 and q is ignored.
// Ports:
//   clock       rising-edge clock
//   reset       asynchronous active-low reset
//   req         per-requester request level
//   cmd         per-requester op, [2i+1:2i]: 00 hold, 01 set, 10 clear, 11 toggle
//   idx         per-requester target bit, [IDX_W*i +: IDX_W]
//   gnt         one-hot grant pulse
//   j, k        registered drive to the bank
//   q           bank readback
//   busy        high whenever the sequencer is not idle
//   done        one-cycle completion pulse
//   err         readback mismatch, alongside done
module jk_bank_arbiter #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8,
   parameter int IDX_W = 3
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [NREQ-1:0]       req,
   input  logic [2*NREQ-1:0]     cmd,
   input  logic [IDX_W*NREQ-1:0] idx,
   output logic [NREQ-1:0]       gnt,
   output logic [WIDTH-1:0]      j,
   output logic [WIDTH-1:0]      k,
   input  logic [WIDTH-1:0]      q,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   localparam logic [1:0] OP_HOLD = 2'b00;
   localparam logic [1:0] OP_SET  = 2'b01;
   localparam logic [1:0] OP_CLR  = 2'b10;
   localparam logic [1:0] OP_TOG  = 2'b11;

`ifdef JK_BANK_ARBITER_VERIFY_EN
   typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_t;
`else
   typedef enum logic [1:0] {IDLE, DRIVE} state_t;
`endif

   state_t             state;
   logic [PTR_W-1:0]   ptr;
   logic [1:0]         op_l;
   logic [IDX_W-1:0]   idx_l;

   // round-robin winner search
   logic               hit;
   logic [PTR_W-1:0]   win;
   logic [PTR_W-1:0]   cand;
   logic [NREQ-1:0]    gmask;
   logic [1:0]         wcmd;
   logic [IDX_W-1:0]   widx;
   logic [PTR_W-1:0]   ptr_next;

   // drive pattern for the latched command
   logic [WIDTH-1:0]   sel;
   logic [WIDTH-1:0]   drive_j;
   logic [WIDTH-1:0]   drive_k;

   always_comb begin
      hit  = 1'b0;
      win  = '0;
      cand = '0;
      for (int i = 0; i < NREQ; i++) begin
         cand = PTR_W'((int'(ptr) + i) % NREQ);
         if (!hit && req[cand]) begin
            hit = 1'b1;
            win = cand;
         end
      end
   end

   always_comb begin
      gmask = '0;
      wcmd  = OP_HOLD;
      widx  = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (PTR_W'(i) == win) begin
            gmask[i] = 1'b1;
            wcmd     = cmd[2*i +: 2];
            widx     = idx[IDX_W*i +: IDX_W];
         end
      end
   end

   assign ptr_next = PTR_W'((int'(win) + 1) % NREQ);

   // An out-of-range idx matches no bit, so it drives nothing and reads back 0.
   always_comb begin
      sel = '0;
      for (int b = 0; b < WIDTH; b++) begin
         sel[b] = (IDX_W'(b) == idx_l);
      end
   end

   assign drive_j = sel & {WIDTH{op_l[0]}};
   assign drive_k = sel & {WIDTH{op_l[1]}};

   assign busy = (state != IDLE);

`ifdef JK_BANK_ARBITER_VERIFY_EN
   logic q_sel;
   logic in_range;
   logic exp_next;
   logic exp_l;

   assign q_sel    = |(q & sel);
   assign in_range = |sel;

   always_comb begin
      exp_next = 1'b0;
      if (in_range) begin
         case (op_l)
            OP_SET:  exp_next = 1'b1;
            OP_CLR:  exp_next = 1'b0;
            OP_TOG:  exp_next = ~q_sel;
            default: exp_next = q_sel;
         endcase
      end
   end

   // The bank only updates on the edge that launches done, so the readback can
   // only be judged while done is high; err is therefore qualified by done.
   assign err = done & (q_sel != exp_l);
`else
   logic unused_q;
   assign unused_q = ^q;
   assign err = 1'b0;
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         ptr   <= '0;
         op_l  <= OP_HOLD;
         idx_l <= '0;
         gnt   <= '0;
         j     <= '0;
         k     <= '0;
         done  <= 1'b0;
`ifdef JK_BANK_ARBITER_VERIFY_EN
         exp_l <= 1'b0;
`endif
      end else begin
         gnt  <= '0;
         j    <= '0;
         k    <= '0;
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (hit) begin
                  gnt   <= gmask;
                  op_l  <= wcmd;
                  idx_l <= widx;
                  ptr   <= ptr_next;
                  state <= DRIVE;
               end
            end
            DRIVE: begin
               j <= drive_j;
               k <= drive_k;
`ifdef JK_BANK_ARBITER_VERIFY_EN
               // q is still the pre-command value here; j/k only act on the next edge
               exp_l <= exp_next;
               state <= CHECK;
`else
               done  <= 1'b1;
               state <= IDLE;
`endif
            end
`ifdef JK_BANK_ARBITER_VERIFY_EN
            CHECK: begin
               done  <= 1'b1;
               state <= IDLE;
            end
`endif
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// tb/tb_jk_bank_arbiter.sv - self-checking bench for jk_bank_arbiter
module tb_jk_bank_arbiter;

   localparam int NREQ  = 4;
   localparam int WIDTH = 8;
   localparam int IDX_W = 3;
   localparam int CW    = 2 * NREQ;
   localparam int XW    = IDX_W * NREQ;
`ifdef JK_BANK_ARBITER_VERIFY_EN
   localparam int LAT = 2;
   localparam bit VER = 1'b1;
`else
   localparam int LAT = 1;
   localparam bit VER = 1'b0;
`endif

   logic             clock = 1'b0;
   logic             reset = 1'b0;
   logic [NREQ-1:0]  req   = '0;
   logic [CW-1:0]    cmd   = '0;
   logic [XW-1:0]    idx   = '0;
   logic [NREQ-1:0]  gnt;
   logic [WIDTH-1:0] j;
   logic [WIDTH-1:0] k;
   logic [WIDTH-1:0] q;
   logic             busy;
   logic             done;
   logic             err;

   logic [WIDTH-1:0] bank       = '0;
   logic [WIDTH-1:0] force_mask = '0;

   int n_cmp  = 0;
   int n_bad  = 0;
   int n_done = 0;
   int n_err  = 0;

   int r_op [NREQ];
   int r_ix [NREQ];

   // reference model state: one command in flight, described by its grant cycle
   int cyc   = 0;
   int m_ptr = 0;
   bit pend  = 1'b0;
   int g_cyc = 0;
   int m_w   = 0;
   int m_op  = 0;
   int m_ix  = 0;
   int old_q = 0;

   jk_bank_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDX_W(IDX_W)) dut (
      .clock (clock),
      .reset (reset),
      .req   (req),
      .cmd   (cmd),
      .idx   (idx),
      .gnt   (gnt),
      .j     (j),
      .k     (k),
      .q     (q),
      .busy  (busy),
      .done  (done),
      .err   (err)
   );

   always #5 clock = ~clock;

   // behavioural JK bank
   always @(posedge clock) begin
      for (int b = 0; b < WIDTH; b++) begin
         case ({j[b], k[b]})
            2'b10:   bank[b] <= 1'b1;
            2'b01:   bank[b] <= 1'b0;
            2'b11:   bank[b] <= ~bank[b];
            default: bank[b] <= bank[b];
         endcase
      end
   end

   assign q = bank & ~force_mask;

   function automatic int q_at(input int ix);
      logic [WIDTH-1:0] s;
      s = q >> ix;
      return (ix < WIDTH) ? int'(s[0]) : 0;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic pack();
      cmd = '0;
      idx = '0;
      for (int i = 0; i < NREQ; i++) begin
         cmd = cmd | (CW'(r_op[i] & 3) << (2 * i));
         idx = idx | (XW'(r_ix[i]) << (IDX_W * i));
      end
   endtask

   // advance the model across the clock edge that just happened
   task automatic model_edge();
      logic [NREQ-1:0] sh;
      bit found;
      cyc++;
      if (!reset) begin
         pend  = 1'b0;
         m_ptr = 0;
         return;
      end
      if (pend && cyc > g_cyc + LAT) pend = 1'b0;
      if (!pend && req != '0) begin
         found = 1'b0;
         for (int i = 0; i < NREQ; i++) begin
            sh = req >> ((m_ptr + i) % NREQ);
            if (!found && sh[0]) begin
               found = 1'b1;
               m_w   = (m_ptr + i) % NREQ;
            end
         end
         m_op  = r_op[m_w];
         m_ix  = r_ix[m_w];
         g_cyc = cyc;
         pend  = 1'b1;
         m_ptr = (m_w + 1) % NREQ;
      end
   endtask

   task automatic compare();
      logic [NREQ-1:0]  eg;
      logic [WIDTH-1:0] ej;
      logic [WIDTH-1:0] ek;
      logic [WIDTH-1:0] bitm;
      logic             eb;
      logic             ed;
      logic             ee;
      int               expv;
      eg = '0; ej = '0; ek = '0; eb = 1'b0; ed = 1'b0; ee = 1'b0; expv = 0;
      if (pend) begin
         bitm = (m_ix < WIDTH) ? (WIDTH'(1) << m_ix) : '0;
         if (cyc == g_cyc) begin
            eg    = NREQ'(1) << m_w;
            old_q = q_at(m_ix);
         end
         if (cyc == g_cyc + 1) begin
            if (m_op == 1 || m_op == 3) ej = bitm;
            if (m_op == 2 || m_op == 3) ek = bitm;
         end
         eb = (cyc < g_cyc + LAT);
         if (cyc == g_cyc + LAT) begin
            ed = 1'b1;
            case (m_op)
               1:       expv = 1;
               2:       expv = 0;
               3:       expv = 1 - old_q;
               default: expv = old_q;
            endcase
            if (m_ix >= WIDTH) expv = 0;
            ee = VER && (q_at(m_ix) != expv);
         end
      end
      chk($sformatf("c%0d_gnt", cyc), gnt, eg);
      chk($sformatf("c%0d_j", cyc), j, ej);
      chk($sformatf("c%0d_k", cyc), k, ek);
      chk($sformatf("c%0d_busy", cyc), busy, eb);
      chk($sformatf("c%0d_done", cyc), done, ed);
      chk($sformatf("c%0d_err", cyc), err, ee);
      if (done) n_done++;
      if (err) n_err++;
   endtask

   task automatic step();
      @(negedge clock);
      model_edge();
      compare();
   endtask

   task automatic drain(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic issue(input int r, input int o, input int x);
      r_op[r] = o;
      r_ix[r] = x;
      pack();
      req = NREQ'(1) << r;
      step();
      req = '0;
      drain(LAT);
      step();
   endtask

   initial begin
      int got [5];
      int at  [5];
      int n;
      int d0;
      int e0;
      int rr_ix [4] = '{7, 6, 4, 1};
      int rr_g  [5] = '{1, 2, 4, 8, 1};

      for (int i = 0; i < NREQ; i++) begin
         r_op[i] = 0;
         r_ix[i] = 0;
      end
      pack();

      // reset held with all requests pending
      reset = 1'b0;
      req   = '1;
      drain(2);
      chk("rst_gnt", gnt, 0);
      chk("rst_j", j, 0);
      chk("rst_k", k, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      reset = 1'b1;
      step();
      chk("rst_first_gnt", gnt, 4'b0001);
      req = '0;
      drain(LAT + 1);

      // single set of bit 3 by requester 0
      r_op[0] = 1;
      r_ix[0] = 3;
      pack();
      req = 4'b0001;
      step();
      chk("set_gnt", gnt, 4'b0001);
      chk("set_busy", busy, 1);
      req = '0;
      step();
      chk("set_j", j, 8'h08);
      chk("set_k", k, 8'h00);
      for (int i = 1; i < LAT; i++) step();
      chk("set_done", done, 1);
      chk("set_err", err, 0);
      step();
      chk("set_q3", q[3], 1);

      // toggle, toggle, clear bit 5 by requester 2
      d0 = n_done;
      e0 = n_err;
      issue(2, 3, 5);
      chk("tog1_q5", q[5], 1);
      issue(2, 3, 5);
      chk("tog2_q5", q[5], 0);
      issue(2, 2, 5);
      chk("clr_q5", q[5], 0);
      chk("tog_done_cnt", n_done - d0, 3);
      chk("tog_err_cnt", n_err - e0, 0);

      // readback mismatch: bit 2 is held low after being set
      r_op[1] = 1;
      r_ix[1] = 2;
      pack();
      req = 4'b0010;
      step();
      req = '0;
      step();
      force_mask = 8'h04;
      for (int i = 1; i < LAT; i++) step();
      chk("mm_done", done, 1);
      chk("mm_err", err, VER);
      step();
      force_mask = '0;
      drain(2);

      // fresh reset, then all four requesters continuously
      reset = 1'b0;
      drain(2);
      reset = 1'b1;
      for (int i = 0; i < NREQ; i++) begin
         r_op[i] = 1;
         r_ix[i] = rr_ix[i];
      end
      pack();
      req = '1;
      n = 0;
      for (int s = 0; s < 5 * (LAT + 1) + 4 && n < 5; s++) begin
         step();
         if (gnt != '0) begin
            got[n] = int'(gnt);
            at[n]  = cyc;
            n++;
         end
      end
      chk("rr_count", n, 5);
      for (int i = 0; i < n; i++) chk($sformatf("rr_gnt%0d", i), got[i], rr_g[i]);
      for (int i = 1; i < n; i++) chk($sformatf("rr_gap%0d", i), at[i] - at[i-1], LAT + 1);
      req = '0;
      drain(LAT + 1);

      // asynchronous reset while j is being driven
      r_op[0] = 1;
      r_ix[0] = 0;
      pack();
      req = 4'b0001;
      step();
      req = '0;
      step();
      chk("rmd_j_before", j, 8'h01);
      #2 reset = 1'b0;
      #1;
      chk("rmd_j_async", j, 0);
      chk("rmd_k_async", k, 0);
      chk("rmd_gnt_async", gnt, 0);
      d0 = n_done;
      drain(2);
      reset = 1'b1;
      drain(3);
      chk("rmd_no_done", n_done - d0, 0);
      for (int i = 0; i < NREQ; i++) r_op[i] = 0;
      pack();
      req = '1;
      step();
      chk("rmd_ptr0", gnt, 4'b0001);
      req = '0;
      drain(LAT + 1);

      // randomized traffic against the model
      for (int s = 0; s < 1500; s++) begin
         for (int i = 0; i < NREQ; i++) begin
            if ($urandom_range(0, 3) == 0) begin
               r_op[i] = int'($urandom_range(0, 3));
               r_ix[i] = int'($urandom_range(0, WIDTH - 1));
            end
         end
         pack();
         req = NREQ'($urandom);
         step();
      end
      req = '0;
      drain(LAT + 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/jk_bank_arbiter.md
# jk_bank_arbiter

Round-robin command arbiter and sequencer for a bank of `WIDTH` JK flip-flops. Up to `NREQ` requesters each post a set / clear / toggle / hold command against one bit of the bank. The block grants one requester at a time and drives that bit's `j`/`k` pair for exactly one clock. It then optionally reads the bit back through `q` and flags a mismatch. It sits between the control logic that owns the flag bits and the `jk_flip_flop` instances that hold them.

## Interface
- `NREQ`, 4: number of requesters (2..8)
- `WIDTH`, 8: number of JK flip-flops in the bank
- `IDX_W`, 3: index width; must satisfy 2^IDX_W >= WIDTH

- `clock`  in  1  single clock, rising-edge
- `reset`  in  1  asynchronous, active-low reset
- `req`  in  NREQ  per-requester request level
- `cmd`  in  2*NREQ  per-requester op, slice [2i+1:2i]: 00 hold, 01 set, 10 clear, 11 toggle
- `idx`  in  IDX_W*NREQ  per-requester target bit, slice [IDX_W*i +: IDX_W]
- `gnt`  out  NREQ  one-hot grant pulse, one cycle
- `j`  out  WIDTH  J inputs to the bank, registered
- `k`  out  WIDTH  K inputs to the bank, registered
- `q`  in  WIDTH  Q outputs fed back from the bank
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse when a command completes
- `err`  out  1  one-cycle pulse alongside `done` on readback mismatch

## Operation
- FSM states: IDLE, DRIVE, CHECK.
- **IDLE**
  - If any `req` is high, select a winner by round-robin starting at pointer `ptr`.
  - Latch the winner's `cmd` and `idx`, pulse `gnt[winner]`, and enter DRIVE.
  - Set `ptr` to (winner+1) mod NREQ.
- **DRIVE**
  - Drive `j[idx]`/`k[idx]` from the latched op: hold 0/0, set 1/0, clear 0/1, toggle 1/1.
  - All other `j`/`k` bits are 0.
  - Sample `q[idx]` and compute the expected value: set 1, clear 0, toggle ~q, hold q.
  - Next state is CHECK.
- **CHECK**
  - Force `j`/`k` to all-zero.
  - Compare `q[idx]` with the expected value.
  - Pulse `done`; pulse `err` if they differ.
  - Return to IDLE.
- `idx` >= WIDTH: the command is still granted but drives no bit. Expected value is 0, and `q` reads as 0 for out-of-range indices.
- A requester must hold `req` until it sees its `gnt`. Dropping `req` before the grant withdraws the request with no side effect.
- If `req` stays high after `gnt`, it is treated as a new request on the next IDLE visit.
- Requests arriving while `busy` wait. Only IDLE evaluates `req`.
- Asynchronous reset (`reset`=0) at any time, including mid-DRIVE:
  - state goes to IDLE and `ptr` to 0;
  - `j`, `k`, `gnt`, `done`, `err` go to 0 immediately;
  - the in-flight command is discarded.

## Timing
- Reset values:
  - `gnt`=0, `j`=0, `k`=0, `busy`=0, `done`=0, `err`=0;
  - state IDLE, `ptr`=0.
- Edge E0: IDLE samples `req`; `gnt` is high during cycle E0→E1, together with `busy`.
- `j`/`k` are high during cycle E1→E2. The flip-flop updates at E2.
- `done`/`err` are high during cycle E2→E3. The FSM is back in IDLE at E3.
- Throughput: one command per 3 cycles (2 cycles without the verify feature).
- With continuous requests from all requesters, grants rotate 0,1,2,…,NREQ-1,0. No requester waits more than NREQ commands.

## Configuration
- Macro: `JK_BANK_ARBITER_VERIFY_EN`.
- **Defined:** CHECK state present and `err` functional, as above.
- **Undefined:**
  - CHECK is removed; DRIVE goes straight to IDLE;
  - `done` pulses during the cycle after DRIVE, which is also the first IDLE cycle;
  - `err` is tied to 0;
  - `q` is unused.

## Test plan
- **Reset:**
  - Hold `reset`=0 for 2 cycles with `req`=4'b1111.
  - Required: `gnt`, `j`, `k`, `busy`, `done`, `err` all 0. First grant after release is `gnt`=4'b0001.
- **Single set:**
  - req0, cmd 01, idx 3, bank all 0.
  - Required: `gnt`=0001 at E0; `j`=8'h08, `k`=0 during E1; `q[3]`=1 after E2; `done`=1, `err`=0 during E2.
- **Toggle then clear:**
  - req2 toggles idx 5 twice, then clears it.
  - Required: `q[5]` goes 0→1→0→0, three `done` pulses, no `err`.
- **Round-robin fairness:**
  - All four `req` held high, each setting a distinct bit.
  - Required: `gnt` sequence 0001, 0010, 0100, 1000, 0001, spaced 3 cycles apart.
- **Mismatch detect:**
  - Bench forces `q[2]`=0 after a set on idx 2.
  - Required: `done`=1 and `err`=1 in the same cycle.
- **Reset mid-DRIVE:**
  - Assert `reset`=0 while `j`=8'h01.
  - Required: `j` goes to 0 without waiting for a clock edge, and no `done` follows. After release, `ptr` restarts at requester 0.
